alu_arb: RTL and testbench

ALU_ARB -- requirements
Module: alu_arb

---
 rtl/alu_arb_pkg.sv | 27 ++
 rtl/alu_arb_grant.sv | 19 +
 rtl/alu_arb.sv | 146 ++++++++++++++
 tb/tb_alu_arb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared opcodes, FSM encoding and widths for the ALU arbiter
// Contents: W_DEF default datapath width, A_* opcode constants,
// state_t FSM encoding, op_legal() opcode range check.
package alu_arb_pkg;

    localparam int W_DEF = 32;

    localparam logic [4:0] A_NOP       = 5'h00;
    localparam logic [4:0] A_ADD       = 5'h01;
    localparam logic [4:0] A_SUB       = 5'h02;
    localparam logic [4:0] A_AND       = 5'h03;
    localparam logic [4:0] A_OR        = 5'h04;
    localparam logic [4:0] A_XOR       = 5'h05;
    localparam logic [4:0] A_NOR       = 5'h06;
    localparam logic [4:0] A_MAX_LEGAL = 5'h06;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [4:0] op);
        return op <= A_MAX_LEGAL;
    endfunction

endpackage

// File: rtl/alu_arb_grant.sv
// rtl/alu_arb_grant.sv - two-way round-robin grant selector
// Ports: valid[1:0] requests, last_grant id of the previous winner,
// grant id of the requester that wins this cycle.
module rr_grant2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        if (valid == 2'b11) begin
            grant = ~last_grant;
        end else if (valid[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arb.sv
// rtl/alu_arb.sv - arbitrates two requesters onto one shared, registered ALU
// Ports: clk, rst (sync, active-high); reqN_valid/ready/a/b/op request
// channels; respN_valid/data/err one-cycle result pulses; alu_a/alu_b/alu_op
// to the shared ALU and alu_out back from it; busy; op_cnt completed ops.
module alu_arb
    import alu_arb_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic [4:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic [4:0]       req1_op,
    output logic             resp0_valid,
    output logic [W-1:0]     resp0_data,
    output logic             resp0_err,
    output logic             resp1_valid,
    output logic [W-1:0]     resp1_data,
    output logic             resp1_err,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [4:0]       alu_op,
    input  logic [W-1:0]     alu_out,
    output logic             busy,
    output logic [CNT_W-1:0] op_cnt
);

    state_t           state_q, state_d;
    logic             last_grant_q;
    logic             lat_id_q;
    logic [W-1:0]     lat_a_q, lat_b_q;
    logic [4:0]       lat_op_q;
    logic [CNT_W-1:0] op_cnt_q;
    logic             grant;
    logic             accept;
    logic             lat_legal;

    rr_grant2 u_grant (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign accept    = (state_q == S_IDLE) && (req0_valid || req1_valid);
    assign lat_legal = op_legal(lat_op_q);
    assign op_cnt    = op_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_op      = A_NOP;
        resp0_valid = 1'b0;
        resp0_data  = '0;
        resp0_err   = 1'b0;
        resp1_valid = 1'b0;
        resp1_data  = '0;
        resp1_err   = 1'b0;
        busy        = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ISSUE;
                    if (grant) begin
                        req1_ready = 1'b1;
                    end else begin
                        req0_ready = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_RESP;
                alu_a   = lat_a_q;
                alu_b   = lat_b_q;
                // Illegal opcodes never reach the ALU; it sees a NOP instead.
                if (lat_legal) begin
                    alu_op = lat_op_q;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (lat_id_q) begin
                    resp1_valid = 1'b1;
                    resp1_data  = lat_legal ? alu_out : '0;
                    resp1_err   = ~lat_legal;
                end else begin
                    resp0_valid = 1'b1;
                    resp0_data  = lat_legal ? alu_out : '0;
                    resp0_err   = ~lat_legal;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // last_grant=1 lets requester 0 win the first tie after reset.
            last_grant_q <= 1'b1;
            lat_id_q     <= 1'b0;
            lat_a_q      <= '0;
            lat_b_q      <= '0;
            lat_op_q     <= A_NOP;
            op_cnt_q     <= '0;
        end else begin
            if (accept) begin
                last_grant_q <= grant;
                lat_id_q     <= grant;
                if (grant) begin
                    lat_a_q  <= req1_a;
                    lat_b_q  <= req1_b;
                    lat_op_q <= req1_op;
                end else begin
                    lat_a_q  <= req0_a;
                    lat_b_q  <= req0_b;
                    lat_op_q <= req0_op;
                end
            end
            if (state_q == S_RESP) begin
                op_cnt_q <= op_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_arb.sv
// tb/tb_alu_arb.sv - scoreboard bench for alu_arb with a registered ALU model
module tb_alu_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [4:0]  req0_op = '0, req1_op = '0;
    logic        resp0_valid, resp1_valid, resp0_err, resp1_err;
    logic [31:0] resp0_data, resp1_data;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_op;
    logic [31:0] alu_out = '0;
    logic        busy;
    logic [15:0] op_cnt;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   exp_cnt = 0;

    alu_arb dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_err(resp0_err),
        .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_err(resp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .busy(busy), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shared ALU: registered result, no reset, NOP holds the last value.
    always @(posedge clk) begin
        case (alu_op)
            5'h01:   alu_out <= alu_a + alu_b;
            5'h02:   alu_out <= alu_a - alu_b;
            5'h03:   alu_out <= alu_a & alu_b;
            5'h04:   alu_out <= alu_a | alu_b;
            5'h05:   alu_out <= alu_a ^ alu_b;
            5'h06:   alu_out <= ~(alu_a | alu_b);
            default: alu_out <= alu_out;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (resp0_valid) begin
            if (q0.size() == 0) begin
                chk("resp0_unexpected", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("resp0_data", resp0_data, e.d);
                chk("resp0_err", {31'd0, resp0_err}, {31'd0, e.e});
                chk("resp0_cycle", cyc, e.c);
            end
        end
        if (resp1_valid) begin
            if (q1.size() == 0) begin
                chk("resp1_unexpected", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("resp1_data", resp1_data, e.d);
                chk("resp1_err", {31'd0, resp1_err}, {31'd0, e.e});
                chk("resp1_cycle", cyc, e.c);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_alu_op", {27'd0, alu_op}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_op_cnt", {16'd0, op_cnt}, 32'd0);
        chk("rst_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic send(input int id, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_d, input logic exp_e);
        exp_t e;
        bit   got;
        got = 0;
        @(negedge clk);
        if (id == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        for (int n = 0; n < 20 && !got; n++) begin
            #1;
            if ((id == 0) ? req0_ready : req1_ready) got = 1;
            else @(negedge clk);
        end
        chk("accept_timeout", {31'd0, got}, 32'd1);
        if (got) begin
            e.d = exp_d; e.e = exp_e; e.c = cyc + 2;
            if (id == 0) q0.push_back(e); else q1.push_back(e);
            exp_cnt++;
            @(posedge clk);
            #1;
            chk("issue_busy", {31'd0, busy}, 32'd1);
            chk("issue_alu_op", {27'd0, alu_op}, (op <= 5'h06) ? {27'd0, op} : 32'd0);
            chk("issue_alu_a", alu_a, a);
            chk("issue_alu_b", alu_b, b);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
        chk("op_cnt", {16'd0, op_cnt}, exp_cnt);
    endtask

    initial begin
        int t0;
        int t1;
        bit got;
        exp_t e;

        // Reset state
        do_reset();

        // Reset during ISSUE aborts the op: no pulse, count stays 0
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 5'h05; req0_a = 32'h1; req0_b = 32'h2;
        #1;
        chk("abort_ready0", {31'd0, req0_ready}, 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        chk("abort_alu_op", {27'd0, alu_op}, 32'h5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        drain();

        // Single ADD, then other ops
        send(0, 5'h01, 32'd5, 32'd7, 32'd12, 1'b0);
        drain();
        send(0, 5'h02, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
        send(1, 5'h05, 32'hA5, 32'hFF, 32'h5A, 1'b0);
        send(0, 5'h06, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
        drain();

        // Tie after reset: requester 0 first, requester 1 three cycles later
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 5'h02; req0_a = 32'd10; req0_b = 32'd3;
        req1_valid = 1'b1; req1_op = 5'h03; req1_a = 32'hF0; req1_b = 32'h3C;
        #1;
        chk("tie_ready0", {31'd0, req0_ready}, 32'd1);
        chk("tie_ready1", {31'd0, req1_ready}, 32'd0);
        t0 = cyc;
        e.d = 32'd7; e.e = 1'b0; e.c = t0 + 2;
        q0.push_back(e);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        chk("wait_ready1", {31'd0, req1_ready}, 32'd0);
        got = 0;
        t1 = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            #1;
            if (req1_ready) begin
                got = 1;
                t1 = cyc;
            end
        end
        chk("tie_accept1", {31'd0, got}, 32'd1);
        chk("tie_gap", t1 - t0, 32'd3);
        e.d = 32'h30; e.e = 1'b0; e.c = t1 + 2;
        q1.push_back(e);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        exp_cnt = 2;
        drain();

        // Illegal opcode
        send(1, 5'h09, 32'd1, 32'd1, 32'd0, 1'b1);
        send(1, 5'h1F, 32'd4, 32'd4, 32'd0, 1'b1);
        // Overflow wraps, then NOP returns held ALU value
        send(0, 5'h01, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0);
        send(0, 5'h00, 32'd9, 32'd9, 32'h8000_0000, 1'b0);
        drain();

        // Counter wrap
        @(negedge clk);
        force dut.op_cnt_q = 16'hFFFF;
        #1;
        release dut.op_cnt_q;
        send(1, 5'h04, 32'h0F, 32'hF0, 32'hFF, 1'b0);
        exp_cnt = 0;
        drain();

        chk("q0_empty", q0.size(), 32'd0);
        chk("q1_empty", q1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
